// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 8;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the master
// that was not granted last wins.
import axi_rd_arb_pkg::*;

module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] winner
);

    always_comb begin
        winner = GNT_NONE;
        unique case (req)
            2'b01:   winner = GNT_M0;
            2'b10:   winner = GNT_M1;
            2'b11:   winner = last_grant ? GNT_M0 : GNT_M1;
            default: winner = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one simplified AXI read port between two masters, round-robin at
// burst granularity; the grant lasts from AR acceptance to the rlast beat.
import axi_rd_arb_pkg::*;

module axi_read_arbiter #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [LEN_WIDTH-1:0]  s0_arlen,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic                  s0_rvalid,
    output logic                  s0_rlast,
    input  logic                  s0_rready,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [LEN_WIDTH-1:0]  s1_arlen,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic                  s1_rvalid,
    output logic                  s1_rlast,
    input  logic                  s1_rready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [LEN_WIDTH-1:0]  m_arlen,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_rvalid,
    input  logic                  m_rlast,
    output logic                  m_rready,
    output logic [1:0]            grant,
    output logic                  burst_err
);

    state_t               state, state_d;
    logic [1:0]           winner;
    logic                 last_grant;  // 1 = master 1 was served last
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic                 in_data;
    logic                 rd_hs;

    rr_arbiter_2 u_arb (
        .req        ({s1_arvalid, s0_arvalid}),
        .last_grant (last_grant),
        .winner     (winner)
    );

    assign in_data = (state == DATA);
    assign rd_hs   = in_data & m_rvalid & m_rready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (|winner) state_d = ADDR;
            ADDR:    if (m_arready) state_d = DATA;
            DATA:    if (rd_hs && m_rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= GNT_NONE;
            m_arvalid  <= 1'b0;
            m_araddr   <= '0;
            m_arlen    <= '0;
            beat_cnt   <= '0;
            last_grant <= 1'b1;
            burst_err  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (|winner) begin
                    grant     <= winner;
                    m_arvalid <= 1'b1;
                    m_araddr  <= winner[1] ? s1_araddr : s0_araddr;
                    m_arlen   <= winner[1] ? s1_arlen  : s0_arlen;
                end
                ADDR: if (m_arready) begin
                    m_arvalid <= 1'b0;
                    beat_cnt  <= '0;
                end
                DATA: if (rd_hs) begin
                    beat_cnt <= beat_cnt + 1'b1;
                    // Flags both an early rlast and a missing rlast on the final counted beat
                    if (m_rlast != (beat_cnt == m_arlen)) burst_err <= 1'b1;
                    if (m_rlast) begin
                        last_grant <= grant[1];
                        grant      <= GNT_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s0_arready = (state == IDLE) & winner[0];
    assign s1_arready = (state == IDLE) & winner[1];

    assign s0_rvalid = in_data & grant[0] & m_rvalid;
    assign s0_rlast  = in_data & grant[0] & m_rlast;
    assign s0_rdata  = (in_data & grant[0]) ? m_rdata : '0;
    assign s1_rvalid = in_data & grant[1] & m_rvalid;
    assign s1_rlast  = in_data & grant[1] & m_rlast;
    assign s1_rdata  = (in_data & grant[1]) ? m_rdata : '0;

    assign m_rready = in_data & ((grant[0] & s0_rready) | (grant[1] & s1_rready));

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a burst table driven through a simple
// memory model, plus hand sequences for reset mid-burst and length boundaries.
module tb_axi_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s0_araddr, s1_araddr, m_araddr;
    logic [7:0]  s0_arlen, s1_arlen, m_arlen;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rlast, s0_rready;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rlast, s1_rready;
    logic [31:0] s0_rdata, s1_rdata, m_rdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
    logic [1:0]  grant;
    logic        burst_err;

    int checks = 0;
    int errors = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    axi_read_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arvalid(s0_arvalid),
        .s0_arready(s0_arready), .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid),
        .s0_rlast(s0_rlast), .s0_rready(s0_rready),
        .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arvalid(s1_arvalid),
        .s1_arready(s1_arready), .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid),
        .s1_rlast(s1_rlast), .s1_rready(s1_rready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .m_rlast(m_rlast), .m_rready(m_rready),
        .grant(grant), .burst_err(burst_err)
    );

    typedef struct {
        logic [1:0]  req;
        int          m;
        logic [31:0] a0;
        logic [7:0]  l0;
        logic [31:0] a1;
        logic [7:0]  l1;
        int          rlast_at;
        int          ar_dly;
        logic [7:0]  rr_pat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serves one burst for master m; requests must already be applied in IDLE.
    task automatic serve(input int m, input logic [31:0] addr, input logic [7:0] len,
                         input int rlast_at, input int ar_dly, input logic [7:0] rr_pat);
        logic [1:0]  exp_g;
        logic        rr;
        int          beat;
        int          cyc;
        bit          done;
        exp_g = (m == 0) ? 2'b01 : 2'b10;
        #1;
        chk("arready_win",  (m == 0) ? s0_arready : s1_arready, 1);
        chk("arready_lose", (m == 0) ? s1_arready : s0_arready, 0);
        tick();
        if (m == 0) s0_arvalid = 1'b0; else s1_arvalid = 1'b0;
        for (int d = 0; d <= ar_dly; d++) begin
            m_arready = (d == ar_dly);
            #1;
            chk("m_arvalid", m_arvalid, 1);
            chk("m_araddr", m_araddr, addr);
            chk("m_arlen", m_arlen, len);
            chk("grant_addr", grant, exp_g);
            chk("arready_busy", {s1_arready, s0_arready}, 0);
            tick();
        end
        m_arready = 1'b0;
        beat = 0; cyc = 0; done = 0;
        while (!done && cyc < 600) begin
            rr = rr_pat[cyc % 8];
            m_rvalid = 1'b1;
            m_rdata  = 32'hD000_0000 + addr + 32'(beat);
            m_rlast  = (beat == rlast_at);
            if (m == 0) s0_rready = rr; else s1_rready = rr;
            #1;
            chk("rvalid", (m == 0) ? s0_rvalid : s1_rvalid, 1);
            chk("rdata", (m == 0) ? s0_rdata : s1_rdata, 32'hD000_0000 + addr + 32'(beat));
            chk("rlast", (m == 0) ? s0_rlast : s1_rlast, (beat == rlast_at));
            chk("other_rvalid", (m == 0) ? s1_rvalid : s0_rvalid, 0);
            chk("other_rdata", (m == 0) ? s1_rdata : s0_rdata, 0);
            chk("m_rready", m_rready, rr);
            chk("m_arvalid_data", m_arvalid, 0);
            tick();
            if (rr) begin
                if (beat == rlast_at) done = 1;
                beat++;
            end
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout: got %0d beats expected %0d", beat, rlast_at + 1);
        end
        if (rlast_at != int'(len)) exp_err = 1'b1;
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
        s0_rready = 1'b0; s1_rready = 1'b0;
        #1;
        chk("grant_end", grant, 2'b00);
        chk("burst_err", burst_err, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s0_araddr = '0; s0_arlen = '0; s0_arvalid = 0; s0_rready = 0;
        s1_araddr = '0; s1_arlen = '0; s1_arvalid = 0; s1_rready = 0;
        m_arready = 0; m_rdata = '0; m_rvalid = 0; m_rlast = 0;

        // req, m, a0, l0, a1, l1, rlast_at, ar_dly, rready pattern
        vecs[0]  = '{2'b11, 0, 32'h40,  8'd2, 32'h20,  8'd1, 2, 0, 8'hFF}; // contention: s0 first
        vecs[1]  = '{2'b10, 1, 32'h40,  8'd2, 32'h20,  8'd1, 1, 0, 8'hFF}; // s1 right after
        vecs[2]  = '{2'b11, 0, 32'h100, 8'd1, 32'h200, 8'd1, 1, 0, 8'hFF}; // fairness x6
        vecs[3]  = '{2'b11, 1, 32'h110, 8'd1, 32'h210, 8'd1, 1, 0, 8'hFF};
        vecs[4]  = '{2'b11, 0, 32'h120, 8'd1, 32'h220, 8'd1, 1, 0, 8'hFF};
        vecs[5]  = '{2'b11, 1, 32'h130, 8'd1, 32'h230, 8'd1, 1, 0, 8'hFF};
        vecs[6]  = '{2'b11, 0, 32'h140, 8'd1, 32'h240, 8'd1, 1, 0, 8'hFF};
        vecs[7]  = '{2'b11, 1, 32'h150, 8'd1, 32'h250, 8'd1, 1, 0, 8'hFF};
        vecs[8]  = '{2'b01, 0, 32'h10,  8'd3, 32'h0,   8'd0, 3, 0, 8'hFF}; // single master
        vecs[9]  = '{2'b10, 1, 32'h0,   8'd0, 32'h30,  8'd7, 7, 3, 8'h99}; // backpressure 1,0,0,1
        vecs[10] = '{2'b01, 0, 32'h50,  8'd3, 32'h0,   8'd0, 1, 0, 8'hFF}; // early rlast
        vecs[11] = '{2'b10, 1, 32'h0,   8'd0, 32'h60,  8'd2, 2, 0, 8'hFF}; // normal after error

        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_araddr", m_araddr, 0);
        chk("rst_m_arlen", m_arlen, 0);
        chk("rst_burst_err", burst_err, 0);
        chk("rst_arready", {s1_arready, s0_arready}, 0);
        chk("rst_m_rready", m_rready, 0);
        tick();

        for (int i = 0; i < 12; i++) begin
            s0_araddr = vecs[i].a0; s0_arlen = vecs[i].l0;
            s1_araddr = vecs[i].a1; s1_arlen = vecs[i].l1;
            s0_arvalid = vecs[i].req[0];
            s1_arvalid = vecs[i].req[1];
            serve(vecs[i].m, (vecs[i].m == 0) ? vecs[i].a0 : vecs[i].a1,
                  (vecs[i].m == 0) ? vecs[i].l0 : vecs[i].l1,
                  vecs[i].rlast_at, vecs[i].ar_dly, vecs[i].rr_pat);
        end
        s0_arvalid = 0; s1_arvalid = 0;
        tick();

        // Reset during beat 1 of an arlen=3 burst from s0
        s0_araddr = 32'h300; s0_arlen = 8'd3; s0_arvalid = 1;
        #1;
        chk("mid_arready", s0_arready, 1);
        tick();
        s0_arvalid = 0; m_arready = 1;
        tick();
        m_arready = 0; m_rvalid = 1; m_rdata = 32'hD000_0300; s0_rready = 1;
        tick();
        m_rdata = 32'hD000_0301; rst = 1;
        #1;
        chk("mid_beat1_rvalid", s0_rvalid, 1);
        tick();
        rst = 0; m_rvalid = 0; s0_rready = 0; m_rdata = '0;
        exp_err = 1'b0;
        #1;
        chk("mid_grant", grant, 2'b00);
        chk("mid_m_arvalid", m_arvalid, 0);
        chk("mid_s0_rvalid", s0_rvalid, 0);
        chk("mid_s1_rvalid", s1_rvalid, 0);
        chk("mid_m_rready", m_rready, 0);
        chk("mid_burst_err", burst_err, 0);
        tick();

        // s1 alone after reset, then a full 256-beat burst from s0
        s1_araddr = 32'h400; s1_arlen = 8'd0; s1_arvalid = 1;
        serve(1, 32'h400, 8'd0, 0, 0, 8'hFF);
        s0_araddr = 32'h1000; s0_arlen = 8'd255; s0_arvalid = 1;
        serve(0, 32'h1000, 8'd255, 255, 1, 8'hFF);

        // Missing rlast on the counted last beat: error set, burst ends on rlast
        s0_araddr = 32'h500; s0_arlen = 8'd1; s0_arvalid = 1;
        serve(0, 32'h500, 8'd1, 2, 0, 8'hFF);
        tick();
        chk("final_idle_grant", grant, 2'b00);
        chk("final_burst_err", burst_err, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
